scan_chain_ctrl: RTL

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

---
 rtl/scan_chain_ctrl_if.sv | 34 +++
 rtl/scan_chain_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/scan_chain_ctrl_if.sv
// Scan chain controller bus: control handshake, serial scan pins and parallel capture/drive.
// The parity signal exists only when SCAN_PARITY_EN is defined.
interface scan_chain_ctrl_if #(
  parameter int WIDTH = 111
);
  logic             start;
  logic             abort;
  logic             s_in;
  logic             s_valid;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] par_out;
  logic             s_out;
  logic             busy;
  logic             done;
`ifdef SCAN_PARITY_EN
  logic             parity;
`endif

  modport master (
    output start, abort, s_in, s_valid, par_in,
    input  par_out, s_out, busy, done
`ifdef SCAN_PARITY_EN
    , input parity
`endif
  );

  modport slave (
    input  start, abort, s_in, s_valid, par_in,
    output par_out, s_out, busy, done
`ifdef SCAN_PARITY_EN
    , output parity
`endif
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Capture/shift/update scan chain controller with a registered parallel drive.
// Define SCAN_PARITY_EN to add an even-parity flag over the bits shifted in.
module scan_chain_ctrl #(
  parameter int WIDTH = 111,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic         clk,
  input logic         rst,
  scan_chain_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, UPDATE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] chain_reg;
  logic [WIDTH-1:0] chain_shifted;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] par_out_reg;
  logic             done_reg;
  logic             busy_reg;
`ifdef SCAN_PARITY_EN
  logic             parity_reg;
`endif

  // A one-bit chain degenerates to a plain load of s_in.
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign chain_shifted = bus.s_in;
    end else begin : g_shift_wide
      assign chain_shifted = {chain_reg[WIDTH-2:0], bus.s_in};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      chain_reg   <= '0;
      cnt_reg     <= '0;
      par_out_reg <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
`ifdef SCAN_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (bus.abort) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start) begin
              state_reg <= CAPTURE;
              busy_reg  <= 1'b1;
            end
          end
          CAPTURE: begin
            chain_reg  <= bus.par_in;
            cnt_reg    <= '0;
`ifdef SCAN_PARITY_EN
            parity_reg <= 1'b0;
`endif
            state_reg  <= SHIFT;
          end
          SHIFT: begin
            if (bus.s_valid) begin
              chain_reg  <= chain_shifted;
              cnt_reg    <= cnt_reg + 1'b1;
`ifdef SCAN_PARITY_EN
              parity_reg <= parity_reg ^ bus.s_in;
`endif
              if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                state_reg <= UPDATE;
              end
            end
          end
          UPDATE: begin
            par_out_reg <= chain_reg;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.par_out = par_out_reg;
  assign bus.s_out   = chain_reg[WIDTH-1];
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
`ifdef SCAN_PARITY_EN
  assign bus.parity  = parity_reg;
`endif
endmodule
